fft_uart_streamer: RTL
======================

# fft_uart_streamer

Frame sequencer that serialises one completed 16-point FFT result frame onto the byte-wide UART transmitter. It latches the whole frame on a valid/ready handshake, then drives the transmitter's start/byte/busy/done handshake byte by byte: header, data words MSB byte first, then an 8-bit checksum. It sits between the FFT output buffer and the UART TX, and is the only master of the transmitter.

## Interface
- N_WORDS, 16: words per frame
- WORD_WIDTH, 16: bits per word; must be a multiple of 8
- HEADER_BYTE, 8'hA5: first byte of every frame
- i_clk  in  1  system clock; all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_frame_valid  in  1  frame available on i_frame_data
- i_frame_data  in  N_WORDS*WORD_WIDTH  packed frame; word 0 in bits [WORD_WIDTH-1:0]
- o_frame_ready  out  1  high in IDLE; frame accepted on the edge where valid and ready are both high
- o_tx_start  out  1  start request to the transmitter
- o_tx_byte  out  8  byte to transmit; stable while o_tx_start is high
- i_tx_busy  in  1  transmitter transfer-in-progress flag
- i_tx_done  in  1  transmitter one-cycle completion pulse
- o_busy  out  1  high from frame acceptance until frame completion
- o_frame_done  out  1  one-cycle pulse after the final byte's i_tx_done

## Operation
- Byte count per frame: NB = N_WORDS*WORD_WIDTH/8 data bytes; total = NB+2 (34 at defaults).
- Byte index 0 is HEADER_BYTE. Indices 1..NB are word 0 MSB byte first, then word 1, and so on. Index NB+1 is the checksum.
- Checksum is the sum modulo 256 of the NB data bytes only; the header is excluded. The accumulator clears on frame acceptance and adds each data byte when that byte is accepted by the transmitter.
- Transmitter contract: the transmitter samples o_tx_start only while idle. i_tx_busy rises the cycle after it accepts a start and falls at the end of the stop bit. i_tx_done pulses for one cycle after that, with the transmitter idle again on the following cycle.
- States:
  - IDLE: o_frame_ready=1. On acceptance, latch the frame, set index=0, clear the checksum and go to SEND.
  - SEND: drive o_tx_start=1 and o_tx_byte=byte[index], but only while i_tx_busy=0. Once i_tx_busy=1 is observed, drop o_tx_start and go to WAIT_DONE.
  - WAIT_DONE: on i_tx_done, either increment index and go to SEND, or, if index==NB+1, pulse o_frame_done and go to IDLE.
- i_frame_valid outside IDLE is ignored; the latched frame is never overwritten mid-transfer.
- If i_tx_busy=1 when SEND is entered (for example after a reset, since the transmitter has no reset), hold o_tx_start=0 until busy falls.
- i_tx_done outside WAIT_DONE is ignored.
- Reset (i_rst_n=0 at an edge), at any point including mid-frame:
  - next state IDLE
  - o_tx_start=0, o_tx_byte=8'h00, o_busy=0, o_frame_done=0, o_frame_ready=1
  - index and checksum cleared; the partial frame is dropped
  - a byte already in flight in the transmitter completes on its own.

## Timing
- Acceptance at edge E. o_busy=1 and o_tx_start=1 with the header byte from cycle E+1, provided i_tx_busy=0.
- o_tx_start stays high until the cycle in which i_tx_busy=1 is sampled. It is low from the following cycle; at least one cycle high per byte.
- i_tx_done high in cycle k: o_tx_start is high with the next byte in cycle k+1, giving zero idle cycles between bytes.
- Final i_tx_done in cycle k: o_frame_done=1 and o_frame_ready=1 in cycle k+1, and o_busy=0 in cycle k+1. A new frame can be accepted at the end of cycle k+1.
- o_tx_byte is registered and changes only on SEND entry.

## Structure
- Package fft_uart_pkg holds:
  - state encoding (IDLE, SEND, WAIT_DONE)
  - HEADER_BYTE default
  - a constant function giving total bytes per frame from N_WORDS and WORD_WIDTH.
- Sub-module fft_uart_byte_sel: a combinational selector of byte[index] from the latched frame, header and checksum; it is shared with the bench's reference model.

## Test plan
- Words 0x0001..0x0010 with the transmitter model -> bytes A5, 00, 01, 00, 02, …, 00, 10, 88. Total 34 starts, one o_frame_done.
- All words 0xFFFF -> A5, then 32×FF, then checksum E0.
- Pulse i_frame_valid again 3 cycles after acceptance with different data -> ignored; the first frame is transmitted unchanged and o_frame_ready stays low until completion.
- Model delays i_tx_busy by 3 cycles after start -> o_tx_start held 3 cycles, single byte sent, no duplicate start.
- Reset asserted during byte 5 with the model's busy still high -> outputs at reset values next cycle. After re-acceptance, no o_tx_start until the model drops busy.
- Measure cycles from each i_tx_done to the next o_tx_start -> exactly 1. From the last i_tx_done to o_frame_done -> exactly 1.

Source files
------------

// File: rtl/fft_uart_pkg.sv
// Shared definitions for the FFT-frame-to-UART sequencer: state encoding,
// default header byte and the bytes-per-frame calculation.
package fft_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_DONE
    } state_e;

    localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;

    // Header + data bytes + checksum.
    function automatic int unsigned total_bytes(input int unsigned n_words,
                                                input int unsigned word_width);
        return (n_words * word_width) / 8 + 2;
    endfunction

endpackage

// File: rtl/fft_uart_streamer_if.sv
// Signal bundle between the FFT output buffer, the frame sequencer and the
// UART transmitter. The slave modport is the sequencer's view.
interface fft_uart_streamer_if #(
    parameter int unsigned N_WORDS    = 16,
    parameter int unsigned WORD_WIDTH = 16
);
    logic                          i_frame_valid;
    logic [N_WORDS*WORD_WIDTH-1:0] i_frame_data;
    logic                          o_frame_ready;
    logic                          o_tx_start;
    logic [7:0]                    o_tx_byte;
    logic                          i_tx_busy;
    logic                          i_tx_done;
    logic                          o_busy;
    logic                          o_frame_done;

    modport slave (
        input  i_frame_valid, i_frame_data, i_tx_busy, i_tx_done,
        output o_frame_ready, o_tx_start, o_tx_byte, o_busy, o_frame_done
    );

    modport master (
        output i_frame_valid, i_frame_data, i_tx_busy, i_tx_done,
        input  o_frame_ready, o_tx_start, o_tx_byte, o_busy, o_frame_done
    );
endinterface

// File: rtl/fft_uart_byte_sel.sv
// Combinational selector of byte[index] within a frame: index 0 is the
// header, 1..NB walk the words MSB byte first, NB+1 is the checksum.
module fft_uart_byte_sel
    import fft_uart_pkg::*;
#(
    parameter int unsigned N_WORDS    = 16,
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned IDX_W      = 6
) (
    input  logic [N_WORDS*WORD_WIDTH-1:0] frame_i,
    input  logic [IDX_W-1:0]              index_i,
    input  logic [7:0]                    header_i,
    input  logic [7:0]                    checksum_i,
    output logic [7:0]                    byte_o
);
    localparam int unsigned TOTAL = total_bytes(N_WORDS, WORD_WIDTH);
    localparam int unsigned NB    = TOTAL - 2;
    localparam int unsigned BPW   = WORD_WIDTH / 8;

    // Map the byte index onto a bit offset in the packed frame.
    always_comb begin
        int unsigned idx;
        int unsigned k;
        int unsigned w;
        int unsigned b;
        int unsigned off;
        idx    = 32'(index_i);
        k      = 0;
        w      = 0;
        b      = 0;
        off    = 0;
        byte_o = '0;
        if (idx == 0) begin
            byte_o = header_i;
        end else if (idx == NB + 1) begin
            byte_o = checksum_i;
        end else if (idx <= NB) begin
            k      = idx - 1;
            w      = k / BPW;
            b      = k % BPW;
            off    = w * WORD_WIDTH + (BPW - 1 - b) * 8;
            byte_o = frame_i[off +: 8];
        end
    end

endmodule

// File: rtl/fft_uart_streamer.sv
// Frame sequencer: latches a full FFT frame, then feeds it to the UART
// transmitter one byte at a time as header, data (MSB byte first), checksum.
module fft_uart_streamer
    import fft_uart_pkg::*;
#(
    parameter int unsigned N_WORDS     = 16,
    parameter int unsigned WORD_WIDTH  = 16,
    parameter logic [7:0]  HEADER_BYTE = HEADER_BYTE_DEF
) (
    input logic              i_clk,
    input logic              i_rst_n,
    fft_uart_streamer_if.slave bus
);
    localparam int unsigned TOTAL = total_bytes(N_WORDS, WORD_WIDTH);
    localparam int unsigned FW    = N_WORDS * WORD_WIDTH;
    localparam int unsigned IDX_W = $clog2(TOTAL + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

    state_e           state_q, state_d;
    logic [FW-1:0]    frame_q, frame_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [7:0]       csum_q, csum_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             frame_done_q, frame_done_d;
    logic             started_q, started_d;
    logic [IDX_W-1:0] sel_idx;
    logic [7:0]       sel_byte;

    // Byte to load on SEND entry: the header on acceptance, else the next index.
    always_comb begin
        sel_idx = (state_q == ST_IDLE) ? '0 : index_q + 1'b1;
    end

    fft_uart_byte_sel #(
        .N_WORDS   (N_WORDS),
        .WORD_WIDTH(WORD_WIDTH),
        .IDX_W     (IDX_W)
    ) u_byte_sel (
        .frame_i   (frame_q),
        .index_i   (sel_idx),
        .header_i  (HEADER_BYTE),
        .checksum_i(csum_q),
        .byte_o    (sel_byte)
    );

    // Next-state logic and outputs.
    // started_q separates a stale busy (transmitter still finishing an older
    // byte, e.g. after reset) from the busy that acknowledges our own start.
    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        index_d      = index_q;
        csum_d       = csum_q;
        tx_byte_d    = tx_byte_q;
        frame_done_d = 1'b0;
        started_d    = started_q;

        bus.o_frame_ready = (state_q == ST_IDLE);
        bus.o_busy        = (state_q != ST_IDLE);
        bus.o_tx_start    = (state_q == ST_SEND) && !bus.i_tx_busy;
        bus.o_tx_byte     = tx_byte_q;
        bus.o_frame_done  = frame_done_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_frame_valid) begin
                    frame_d   = bus.i_frame_data;
                    index_d   = '0;
                    csum_d    = '0;
                    tx_byte_d = sel_byte;
                    started_d = 1'b0;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!bus.i_tx_busy) begin
                    started_d = 1'b1;
                end else if (started_q) begin
                    if (index_q != '0 && index_q != LAST_IDX) begin
                        csum_d = csum_q + tx_byte_q;
                    end
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.i_tx_done) begin
                    if (index_q == LAST_IDX) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        index_d   = index_q + 1'b1;
                        tx_byte_d = sel_byte;
                        started_d = 1'b0;
                        state_d   = ST_SEND;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Control and datapath registers; a reset drops any partial frame.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            index_q      <= '0;
            csum_q       <= '0;
            tx_byte_q    <= '0;
            frame_done_q <= 1'b0;
            started_q    <= 1'b0;
        end else begin
            index_q      <= index_d;
            csum_q       <= csum_d;
            tx_byte_q    <= tx_byte_d;
            frame_done_q <= frame_done_d;
            started_q    <= started_d;
        end
    end

    // Latched frame; only rewritten on acceptance, so no reset is needed.
    always_ff @(posedge i_clk) begin
        frame_q <= frame_d;
    end

endmodule
